// File: rtl/femto_clkdiv.sv
// femto_clkdiv: lock-qualified reset sequencer plus NCH run-time programmable clock-enable dividers.
// Build macro CLKDIV_LOCKLOSS_CNT_EN adds the saturating lockloss_cnt output.
module femto_clkdiv #(
    parameter int                NCH         = 4,
    parameter int                DW          = 16,
    parameter logic [NCH*DW-1:0] DIV_INIT    = '0,
    parameter int                LOCK_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           pll_locked,
    input  logic           cfg_we,
    input  logic [2:0]     cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    output logic [NCH-1:0] ce,
    output logic           rst_out_n,
    output logic           ready
`ifdef CLKDIV_LOCKLOSS_CNT_EN
    ,
    output logic [7:0]     lockloss_cnt
`endif
);

    localparam int            CW         = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          lock_meta, lock_sync;
    logic          rst_q;
    logic          run_active;

    // pll_locked comes from another timing domain; two flops before anything decodes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking so lock_sync takes the old lock_meta, giving a real 2-stage chain.
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= WAIT_LOCK;
            count <= '0;
            rst_q <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            rst_q <= (state_nxt == RUN);
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nxt = state;
        count_nxt = '0;
        case (state)
            WAIT_LOCK: begin
                if (lock_sync) state_nxt = STABILIZE;
            end
            STABILIZE: begin
                if (!lock_sync)                state_nxt = WAIT_LOCK;
                else if (count == COUNT_LAST)  state_nxt = RUN;
                else                           count_nxt = count + 1'b1;
            end
            RUN: begin
                if (!lock_sync) state_nxt = WAIT_LOCK;
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // Gating with lock_sync drops the outputs in the very cycle the lock loss is seen,
    // one edge before the state register itself leaves RUN.
    assign run_active = (state == RUN) && lock_sync;
    assign ready      = run_active;
    assign rst_out_n  = rst_q && lock_sync;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] div_q;
        logic [DW-1:0] cnt_q;
        logic          hit;

        // Channel indices >= NCH never match, so such writes fall through harmlessly.
        assign hit   = cfg_we && (cfg_ch == 3'(i));
        assign ce[i] = run_active && (cnt_q == div_q);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                // NOTE: dividers are programmable registers, not a memory; they must reset to DIV_INIT.
                div_q <= DIV_INIT[i*DW +: DW];
                cnt_q <= '0;
            end else if (hit) begin
                div_q <= cfg_div;
                cnt_q <= '0;
            end else if (run_active && !ce[i]) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

`ifdef CLKDIV_LOCKLOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loss_q <= '0;
        end else if ((state == RUN) && (state_nxt == WAIT_LOCK) && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lockloss_cnt = loss_q;
`endif

endmodule
